// File: rtl/text_pkg.sv
// Shared geometry, control codes and FSM encoding for the text buffer writer.
package text_pkg;

    localparam int unsigned ROW_NUMBER        = 15;
    localparam int unsigned COL_NUMBER        = 40;
    localparam int unsigned ROW_BIT_LEN       = 4;
    localparam int unsigned COL_BIT_LEN       = 6;
    localparam int unsigned CHAR_ID_LENGTH    = 8;
    localparam int unsigned CELL_ADDR_BIT_LEN = 10;
    localparam int unsigned CELL_COUNT        = ROW_NUMBER * COL_NUMBER;

    localparam logic [CHAR_ID_LENGTH-1:0] BLANK_ID  = 8'h20;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_BS     = 8'h08;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_LF     = 8'h0A;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_FF     = 8'h0C;
    localparam logic [CHAR_ID_LENGTH-1:0] CC_CR     = 8'h0D;
    localparam logic [CHAR_ID_LENGTH-1:0] PRINT_MIN = 8'h20;
    localparam logic [CHAR_ID_LENGTH-1:0] PRINT_MAX = 8'h7E;

    localparam logic [ROW_BIT_LEN-1:0] ROW_LIMIT = ROW_BIT_LEN'(ROW_NUMBER);
    localparam logic [COL_BIT_LEN-1:0] COL_LIMIT = COL_BIT_LEN'(COL_NUMBER);
    localparam logic [ROW_BIT_LEN-1:0] LAST_ROW  = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] LAST_COL  = COL_BIT_LEN'(COL_NUMBER - 1);

    localparam logic [CELL_ADDR_BIT_LEN-1:0] ROW_STRIDE   = CELL_ADDR_BIT_LEN'(COL_NUMBER);
    localparam logic [CELL_ADDR_BIT_LEN-1:0] LAST_CELL    = CELL_ADDR_BIT_LEN'(CELL_COUNT - 1);
    localparam logic [CELL_ADDR_BIT_LEN-1:0] COPY_LAST    = CELL_ADDR_BIT_LEN'(CELL_COUNT - COL_NUMBER - 1);
    localparam logic [CELL_ADDR_BIT_LEN-1:0] BLANK_FIRST  = CELL_ADDR_BIT_LEN'(CELL_COUNT - COL_NUMBER);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCROLL_COPY,
        ST_SCROLL_BLANK
    } state_e;

    function automatic logic [CELL_ADDR_BIT_LEN-1:0] cell_addr(
        input logic [ROW_BIT_LEN-1:0] row,
        input logic [COL_BIT_LEN-1:0] col
    );
        return CELL_ADDR_BIT_LEN'(row) * ROW_STRIDE + CELL_ADDR_BIT_LEN'(col);
    endfunction

endpackage

// File: rtl/text_buffer_writer_ram.sv
// Character cell store: one synchronous write port, two asynchronous read ports.
module text_ram
    import text_pkg::*;
(
    input  logic                         clk,
    input  logic                         we,
    input  logic [CELL_ADDR_BIT_LEN-1:0] waddr,
    input  logic [CHAR_ID_LENGTH-1:0]    wdata,
    input  logic [CELL_ADDR_BIT_LEN-1:0] raddr_a,
    output logic [CHAR_ID_LENGTH-1:0]    rdata_a,
    input  logic [CELL_ADDR_BIT_LEN-1:0] raddr_b,
    output logic [CHAR_ID_LENGTH-1:0]    rdata_b
);

    logic [CHAR_ID_LENGTH-1:0] mem [CELL_COUNT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
    end

endmodule

// File: rtl/text_buffer_writer.sv
// Text buffer writer: cursor handling, control codes, clear and scroll sweeps.
module text_buffer_writer
    import text_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHAR_ID_LENGTH-1:0] char_in,
    input  logic                      char_valid,
    output logic                      char_ready,
    input  logic [ROW_BIT_LEN-1:0]    char_row,
    input  logic [COL_BIT_LEN-1:0]    char_col,
    output logic [CHAR_ID_LENGTH-1:0] character_id,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col,
    output logic                      busy
);

    state_e                         state_q, state_d;
    logic [CELL_ADDR_BIT_LEN-1:0]   idx_q, idx_d;
    logic [ROW_BIT_LEN-1:0]         row_q, row_d;
    logic [COL_BIT_LEN-1:0]         col_q, col_d;

    logic                           we;
    logic [CELL_ADDR_BIT_LEN-1:0]   waddr;
    logic [CHAR_ID_LENGTH-1:0]      wdata;
    logic [CELL_ADDR_BIT_LEN-1:0]   raddr_a;
    logic [CHAR_ID_LENGTH-1:0]      rdata_a;
    logic [CHAR_ID_LENGTH-1:0]      rdata_b;
    logic                           in_range;
    logic                           line_break;

    text_ram u_ram (
        .clk     (clk),
        .we      (we && !reset),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (idx_q + ROW_STRIDE),
        .rdata_b (rdata_b)
    );

    always_comb begin
        in_range     = (char_row < ROW_LIMIT) && (char_col < COL_LIMIT);
        raddr_a      = in_range ? cell_addr(char_row, char_col) : '0;
        character_id = in_range ? rdata_a : BLANK_ID;
        char_ready   = (state_q == ST_IDLE) && !reset;
        busy         = !char_ready;
        cursor_row   = row_q;
        cursor_col   = col_q;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        we         = 1'b0;
        waddr      = idx_q;
        wdata      = BLANK_ID;
        line_break = 1'b0;

        case (state_q)
            ST_CLEAR, ST_SCROLL_BLANK: begin
                we = 1'b1;
                if (idx_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 10'd1;
                end
            end
            ST_SCROLL_COPY: begin
                we    = 1'b1;
                wdata = rdata_b;
                if (idx_q == COPY_LAST) begin
                    state_d = ST_SCROLL_BLANK;
                    idx_d   = BLANK_FIRST;
                end else begin
                    idx_d = idx_q + 10'd1;
                end
            end
            ST_IDLE: begin
                if (char_valid) begin
                    if (char_in >= PRINT_MIN && char_in <= PRINT_MAX) begin
                        we    = 1'b1;
                        waddr = cell_addr(row_q, col_q);
                        wdata = char_in;
                        if (col_q < LAST_COL) begin
                            col_d = col_q + 6'd1;
                        end else begin
                            line_break = 1'b1;
                        end
                    end else if (char_in == CC_LF || char_in == CC_CR) begin
                        line_break = 1'b1;
                    end else if (char_in == CC_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - 6'd1;
                            we    = 1'b1;
                            waddr = cell_addr(row_q, col_q - 6'd1);
                        end else if (row_q != '0) begin
                            row_d = row_q - 4'd1;
                            col_d = LAST_COL;
                            we    = 1'b1;
                            waddr = cell_addr(row_q - 4'd1, LAST_COL);
                        end
                    end else if (char_in == CC_FF) begin
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = ST_CLEAR;
                    end
                end
                // Wrap and newline share one path; the bottom row triggers a scroll sweep.
                if (line_break) begin
                    col_d = '0;
                    if (row_q < LAST_ROW) begin
                        row_d = row_q + 4'd1;
                    end else begin
                        row_d   = LAST_ROW;
                        idx_d   = '0;
                        state_d = ST_SCROLL_COPY;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Self-checking bench for text_buffer_writer: directed scenarios plus random traffic vs a screen model.
module tb_text_buffer_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [3:0] char_row = 4'd0;
    logic [5:0] char_col = 6'd0;
    logic [7:0] character_id;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    int total = 0;
    int bad = 0;

    text_buffer_writer dut (
        .clk          (clk),
        .reset        (reset),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .char_row     (char_row),
        .char_col     (char_col),
        .character_id (character_id),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Screen model: whole-screen effects applied at the accepting edge, plus a ready-low countdown.
    int  mm [600];
    int  m_row = 0;
    int  m_col = 0;
    int  m_wait = 600;
    bit  m_live = 1'b0;

    function automatic int m_read(input int r, input int c);
        if (r >= 15 || c >= 40) return 32;
        return mm[r * 40 + c];
    endfunction

    task automatic m_blank_all();
        for (int i = 0; i < 600; i++) mm[i] = 32;
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row < 14) begin
            m_row++;
        end else begin
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 40; c++)
                    mm[r * 40 + c] = mm[(r + 1) * 40 + c];
            for (int c = 0; c < 40; c++) mm[14 * 40 + c] = 32;
            m_row = 14;
            m_wait = 600;
        end
    endtask

    task automatic m_apply(input int c);
        if (c >= 32 && c <= 126) begin
            mm[m_row * 40 + m_col] = c;
            if (m_col < 39) m_col++;
            else m_newline();
        end else if (c == 10 || c == 13) begin
            m_newline();
        end else if (c == 8) begin
            if (m_col > 0) begin
                m_col--;
                mm[m_row * 40 + m_col] = 32;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 39;
                mm[m_row * 40 + m_col] = 32;
            end
        end else if (c == 12) begin
            m_blank_all();
            m_row = 0;
            m_col = 0;
            m_wait = 600;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_live = 1'b1;
                m_wait = 600;
                m_row = 0;
                m_col = 0;
                m_blank_all();
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (char_valid) begin
                m_apply(int'(char_in));
            end
        end
    end

    initial begin
        bit exp_ready;
        forever begin
            @(negedge clk);
            if (m_live) begin
                exp_ready = !reset && (m_wait == 0);
                check("char_ready", int'(char_ready), int'(exp_ready));
                check("busy", int'(busy), int'(!exp_ready));
                check("cursor_row", int'(cursor_row), m_row);
                check("cursor_col", int'(cursor_col), m_col);
                if (exp_ready)
                    check("character_id", int'(character_id), m_read(int'(char_row), int'(char_col)));
            end
        end
    end

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!char_ready && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!char_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] code, output int n);
        char_in = code;
        char_valid = 1'b1;
        wait_ready(700, n);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic expect_cell(input string name, input int r, input int c, input int exp);
        char_row = 4'(r);
        char_col = 6'(c);
        #1;
        check(name, int'(character_id), exp);
    endtask

    task automatic scan_all();
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                char_row = 4'(r);
                char_col = 6'(c);
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 78) return 8'h0A;
        if (r < 82) return 8'h0D;
        if (r < 92) return 8'h08;
        if (r < 93) return 8'h0C;
        if (r < 96) return 8'h07;
        return 8'($urandom_range(128, 255));
    endfunction

    initial begin
        int n;
        bit acc;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready(700, n);
        check("reset_to_ready_cycles", n, 600);
        check("reset_cursor_row", int'(cursor_row), 0);
        check("reset_cursor_col", int'(cursor_col), 0);
        scan_all();

        send(8'h41, n);
        send(8'h42, n);
        expect_cell("cell_0_0_A", 0, 0, 8'h41);
        expect_cell("cell_0_1_B", 0, 1, 8'h42);
        check("ab_cursor_col", int'(cursor_col), 2);
        check("ab_ready", int'(char_ready), 1);

        send(8'h0C, n);
        wait_ready(700, n);
        for (int i = 0; i < 40; i++) send(8'(8'h61 + (i % 26)), n);
        check("wrap_cursor_row", int'(cursor_row), 1);
        check("wrap_cursor_col", int'(cursor_col), 0);
        send(8'h08, n);
        check("bs_cursor_row", int'(cursor_row), 0);
        check("bs_cursor_col", int'(cursor_col), 39);
        expect_cell("bs_cell_0_39", 0, 39, 8'h20);
        expect_cell("bs_cell_0_38", 0, 38, 8'h61 + 38 % 26);

        send(8'h0C, n);
        wait_ready(700, n);
        send(8'h0A, n);
        send(8'h58, n);
        for (int i = 0; i < 13; i++) send(8'h0A, n);
        send(8'h59, n);
        for (int i = 0; i < 4; i++) send(8'h7A, n);
        check("pre_scroll_row", int'(cursor_row), 14);
        check("pre_scroll_col", int'(cursor_col), 5);
        send(8'h0A, n);
        check("scroll_cursor_row", int'(cursor_row), 14);
        check("scroll_cursor_col", int'(cursor_col), 0);
        check("scroll_busy", int'(busy), 1);
        send(8'h43, n);
        check("scroll_busy_cycles", n, 600);
        expect_cell("scroll_0_0", 0, 0, 8'h58);
        expect_cell("scroll_13_0", 13, 0, 8'h59);
        expect_cell("held_char_14_0", 14, 0, 8'h43);
        for (int c = 1; c < 40; c++) expect_cell("scroll_row14_blank", 14, c, 8'h20);
        check("held_cursor_col", int'(cursor_col), 1);

        expect_cell("oob_row", 15, 0, 8'h20);
        expect_cell("oob_col", 0, 40, 8'h20);
        send(8'h0C, n);
        send(8'h07, n);
        check("ff_clear_cycles", n, 600);
        check("ff_cursor_row", int'(cursor_row), 0);
        check("ff_cursor_col", int'(cursor_col), 0);
        expect_cell("ff_cell_0_0", 0, 0, 8'h20);
        scan_all();

        acc = 1'b1;
        for (int it = 0; it < 5000; it++) begin
            reset = (it == 2500);
            char_row = 4'($urandom_range(0, 15));
            char_col = 6'($urandom_range(0, 63));
            if (acc || !char_valid) begin
                if ($urandom_range(0, 9) < 7) begin
                    char_valid = 1'b1;
                    char_in = pick_code();
                end else begin
                    char_valid = 1'b0;
                end
            end
            @(negedge clk);
            acc = (char_valid && char_ready) || reset;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        char_valid = 1'b0;
        wait_ready(700, n);
        scan_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
